// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants for the RV32 integer register file.
//   XLEN     data width
//   NREGS    number of architectural registers
//   AW       register index width
//   REG_ZERO hardwired-zero register index
//   REG_SP   stack pointer register index
//   SP_INIT  stack pointer reset value
package regfile_pkg;
    localparam int          XLEN     = 32;
    localparam int          NREGS    = 32;
    localparam int          AW       = $clog2(NREGS);
    localparam int          REG_ZERO = 0;
    localparam int          REG_SP   = 2;
    localparam logic [31:0] SP_INIT  = 32'h2ffc;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending bits marking registers whose producer has
// issued but not yet written back, plus the per-read-port busy lookup.
//   clk, reset          clock, synchronous active-high reset
//   iss_en, iss_addr    issued instruction destination (sets pending)
//   wr0_*, wr1_*        writeback enables/addresses (clear pending)
//   rd_addr             NRD packed read addresses
//   rd_busy             NRD busy flags, one per read port
module reg_scoreboard #(
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    input  logic              wr0_en,
    input  logic [AW-1:0]     wr0_addr,
    input  logic              wr1_en,
    input  logic [AW-1:0]     wr1_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy
);
    import regfile_pkg::*;

    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] set_vec;
    logic [NREGS-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_en && iss_addr != AW'(REG_ZERO)) set_vec[iss_addr] = 1'b1;
        if (wr0_en) clr_vec[wr0_addr] = 1'b1;
        if (wr1_en) clr_vec[wr1_addr] = 1'b1;
    end

    // Issue is applied after clear so a same-cycle re-issue keeps the bit set
    // for the new producer. Bit 0 is never set, so x0 is never pending.
    always_ff @(posedge clk) begin
        if (reset) pending <= '0;
        else       pending <= (pending & ~clr_vec) | set_vec;
    end

    // With bypass, a register written this cycle is already forwarded, so it is
    // not busy unless a new producer is issuing to it in the same cycle.
    for (genvar k = 0; k < NRD; k++) begin : g_busy
        logic [AW-1:0] a;
        assign a          = rd_addr[k*AW +: AW];
        assign rd_busy[k] = pending[a] && !(BYPASS != 0 && clr_vec[a] && !set_vec[a]);
    end
endmodule

// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: integer register file with NRD async read ports, two
// synchronous write ports (wr1/LSU wins on conflict), optional write->read
// bypass and a pending scoreboard for RAW hazard detection.
//   clk, reset          clock, synchronous active-high reset
//   rd_addr, rd_data    NRD packed read addresses / data
//   rd_busy             per-port pending-producer flag
//   wr0_*, wr1_*        write ports (ALU/CSR, LSU)
//   iss_en, iss_addr    issued instruction destination
//   dbg_addr, dbg_data  debug read of raw array contents (never bypassed)
module regfile_bypass_sb #(
    parameter int          XLEN    = regfile_pkg::XLEN,
    parameter int          NREGS   = regfile_pkg::NREGS,
    parameter int          NRD     = 2,
    parameter int          BYPASS  = 1,
    parameter int          SP_IDX  = regfile_pkg::REG_SP,
    parameter logic [XLEN-1:0] SP_INIT = XLEN'(regfile_pkg::SP_INIT),
    parameter int          AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr0_en,
    input  logic [AW-1:0]       wr0_addr,
    input  logic [XLEN-1:0]     wr0_data,
    input  logic                wr1_en,
    input  logic [AW-1:0]       wr1_addr,
    input  logic [XLEN-1:0]     wr1_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);
    import regfile_pkg::*;

    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $error("regfile_bypass_sb: NRD must be 1..4");
    end
    if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("regfile_bypass_sb: NREGS must be a power of 2");
    end

    logic [XLEN-1:0] regs [NREGS];
    logic            wr0_ok;
    logic            wr1_ok;

    assign wr0_ok = wr0_en && wr0_addr != AW'(REG_ZERO);
    assign wr1_ok = wr1_en && wr1_addr != AW'(REG_ZERO);

    // wr1 is assigned last so it wins when both ports target the same register.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= (i == SP_IDX && i != REG_ZERO) ? SP_INIT : '0;
        end else begin
            if (wr0_ok) regs[wr0_addr] <= wr0_data;
            if (wr1_ok) regs[wr1_addr] <= wr1_data;
        end
    end

    // regs[0] is never written and resets to 0, so x0 reads need no special case;
    // wr*_ok already exclude x0 from the bypass path.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          hit0;
        logic          hit1;
        assign a    = rd_addr[k*AW +: AW];
        assign hit0 = BYPASS != 0 && wr0_ok && wr0_addr == a;
        assign hit1 = BYPASS != 0 && wr1_ok && wr1_addr == a;
        assign rd_data[k*XLEN +: XLEN] = hit1 ? wr1_data : hit0 ? wr0_data : regs[a];
    end

    assign dbg_data = regs[dbg_addr];

    reg_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .BYPASS(BYPASS),
        .AW    (AW)
    ) u_sb (
        .clk     (clk),
        .reset   (reset),
        .iss_en  (iss_en),
        .iss_addr(iss_addr),
        .wr0_en  (wr0_en),
        .wr0_addr(wr0_addr),
        .wr1_en  (wr1_en),
        .wr1_addr(wr1_addr),
        .rd_addr (rd_addr),
        .rd_busy (rd_busy)
    );
endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb_regfile_bypass_sb: directed bench for regfile_bypass_sb, BYPASS=1 and BYPASS=0
// instances side by side, checked against an array-level reference model.
`timescale 1ns/1ps
module tb_regfile_bypass_sb;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ra0, ra1;
    logic        wr0_en, wr1_en, iss_en;
    logic [4:0]  wr0_addr, wr1_addr, iss_addr, dbg_addr;
    logic [31:0] wr0_data, wr1_data;
    logic [63:0] rd_data_b, rd_data_n;
    logic [1:0]  rd_busy_b, rd_busy_n;
    logic [31:0] dbg_b, dbg_n;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;

    logic [31:0] m_reg [32];
    bit          m_pend [32];

    always #5 clk = ~clk;

    regfile_bypass_sb #(.BYPASS(1)) dut (
        .clk(clk), .reset(reset), .rd_addr({ra1, ra0}), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_b));

    regfile_bypass_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset(reset), .rd_addr({ra1, ra0}), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
        .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .dbg_addr(dbg_addr), .dbg_data(dbg_n));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 0) return 0;
        if (byp && wr1_en && wr1_addr == a) return wr1_data;
        if (byp && wr0_en && wr0_addr == a) return wr0_data;
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a, input bit byp);
        bit written = (wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a);
        bit reiss   = iss_en && iss_addr == a;
        if (a == 0) return 1'b0;
        if (byp && written && !reiss) return 1'b0;
        return m_pend[a];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            foreach (m_reg[i]) begin
                m_reg[i]  = (i == 2) ? 32'h2ffc : 32'h0;
                m_pend[i] = 0;
            end
        end else begin
            if (wr0_en && wr0_addr != 0) m_reg[wr0_addr] = wr0_data;
            if (wr1_en && wr1_addr != 0) m_reg[wr1_addr] = wr1_data;
            if (wr0_en) m_pend[wr0_addr] = 0;
            if (wr1_en) m_pend[wr1_addr] = 0;
            if (iss_en && iss_addr != 0) m_pend[iss_addr] = 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("byp rd0",   rd_data_b[31:0],  exp_rd(ra0, 1));
            chk("byp rd1",   rd_data_b[63:32], exp_rd(ra1, 1));
            chk("nb rd0",    rd_data_n[31:0],  exp_rd(ra0, 0));
            chk("nb rd1",    rd_data_n[63:32], exp_rd(ra1, 0));
            chk("byp busy",  {30'b0, rd_busy_b}, {30'b0, exp_busy(ra1, 1), exp_busy(ra0, 1)});
            chk("nb busy",   {30'b0, rd_busy_n}, {30'b0, exp_busy(ra1, 0), exp_busy(ra0, 0)});
            chk("byp dbg",   dbg_b, m_reg[dbg_addr]);
            chk("nb dbg",    dbg_n, m_reg[dbg_addr]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        wr0_en = 0; wr1_en = 0; iss_en = 0;
    endtask

    initial begin
        reset = 1; ra0 = 0; ra1 = 0; dbg_addr = 0;
        wr0_en = 0; wr1_en = 0; iss_en = 0;
        wr0_addr = 0; wr1_addr = 0; iss_addr = 0; wr0_data = 0; wr1_data = 0;
        cyc();
        reset = 0;
        chk_en = 1;
        // 1: reset contents
        for (int d = 0; d < 32; d++) begin
            dbg_addr = 5'(d);
            #1;
            chk("reset dbg", dbg_b, (d == 2) ? 32'h2ffc : 32'h0);
            if (d < 31) cyc();
        end
        chk("reset busy", {30'b0, rd_busy_b}, 32'h0);
        // 2: x0 hardwired
        cyc(); wr0_en = 1; wr0_addr = 0; wr0_data = 32'hdeadbeef; ra0 = 0; #1;
        chk("x0 bypass", rd_data_b[31:0], 32'h0);
        cyc(); dbg_addr = 0; #1;
        chk("x0 after", rd_data_b[31:0], 32'h0);
        chk("x0 dbg", dbg_b, 32'h0);
        // 3: bypass vs old value
        cyc(); wr0_en = 1; wr0_addr = 5; wr0_data = 32'h11; ra0 = 5; #1;
        chk("x5 bypass", rd_data_b[31:0], 32'h11);
        chk("x5 nobypass", rd_data_n[31:0], 32'h0);
        cyc(); #1;
        chk("x5 array", rd_data_n[31:0], 32'h11);
        // 4: wr1 wins
        cyc(); wr0_en = 1; wr0_addr = 7; wr0_data = 32'haaaa;
        wr1_en = 1; wr1_addr = 7; wr1_data = 32'h5555; ra1 = 7; #1;
        chk("x7 bypass", rd_data_b[63:32], 32'h5555);
        cyc(); dbg_addr = 7; #1;
        chk("x7 dbg", dbg_b, 32'h5555);
        chk("x7 dbg nb", dbg_n, 32'h5555);
        // 5: scoreboard
        cyc(); iss_en = 1; iss_addr = 9; ra0 = 9; #1;
        chk("x9 not yet", {31'b0, rd_busy_b[0]}, 32'h0);
        cyc(); #1;
        chk("x9 busy", {31'b0, rd_busy_b[0]}, 32'h1);
        cyc(); wr1_en = 1; wr1_addr = 9; wr1_data = 32'h77; iss_en = 1; iss_addr = 9; #1;
        chk("x9 reissue", {31'b0, rd_busy_b[0]}, 32'h1);
        cyc(); #1;
        chk("x9 still", {31'b0, rd_busy_b[0]}, 32'h1);
        cyc(); wr0_en = 1; wr0_addr = 9; wr0_data = 32'h99; #1;
        chk("x9 wb byp", {31'b0, rd_busy_b[0]}, 32'h0);
        chk("x9 wb nb", {31'b0, rd_busy_n[0]}, 32'h1);
        cyc(); #1;
        chk("x9 clear", {31'b0, rd_busy_n[0]}, 32'h0);
        cyc(); iss_en = 1; iss_addr = 0; ra0 = 0;
        cyc(); #1;
        chk("x0 never busy", {31'b0, rd_busy_n[0]}, 32'h0);
        // extra directed writes on both ports
        for (int i = 1; i <= 6; i++) begin
            cyc();
            wr0_en = 1; wr0_addr = 5'(i + 10); wr0_data = 32'h101 * i;
            wr1_en = 1; wr1_addr = 5'(i + 20); wr1_data = ~32'(i);
            iss_en = 1; iss_addr = 5'(i + 12);
            ra0 = 5'(i + 10); ra1 = 5'(i + 12); dbg_addr = 5'(i + 19);
        end
        cyc(); #1;
        chk("x16 lit", rd_data_n[31:0], 32'h606);
        // 6: mid-stream reset
        cyc(); iss_en = 1; iss_addr = 3;
        cyc(); wr0_en = 1; wr0_addr = 4; wr0_data = 7;
        cyc(); ra0 = 4; ra1 = 3; #1;
        chk("x4 written", rd_data_n[31:0], 32'h7);
        chk("x3 pending", {31'b0, rd_busy_n[1]}, 32'h1);
        cyc(); reset = 1; wr0_en = 1; wr0_addr = 4; wr0_data = 32'h123; iss_en = 1; iss_addr = 5;
        cyc(); reset = 0; dbg_addr = 2; #1;
        chk("rst x4", rd_data_n[31:0], 32'h0);
        chk("rst x3 busy", {31'b0, rd_busy_n[1]}, 32'h0);
        chk("rst sp", dbg_n, 32'h2ffc);
        ra0 = 5; #1;
        chk("rst x5 busy", {31'b0, rd_busy_n[0]}, 32'h0);
        cyc(); cyc();
        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
